// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO on inferred RAM with optional first-word-fall-through output,
// programmable almost-full/almost-empty levels, fill count, flush and sticky error flags.
module sync_fifo_ctl #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 8,
  parameter int FWFT         = 0,
  parameter int AFULL_LEVEL  = DEPTH - 1,
  parameter int AEMPTY_LEVEL = 1,
  parameter int CW           = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr,
  input  logic             rd,
  input  logic             flush,
  input  logic             clear_errors,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(AFULL_LEVEL);
  localparam logic [CW-1:0] AE_LVL   = CW'(AEMPTY_LEVEL);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if (DEPTH < 2) begin : g_bad_depth
    $fatal(1, "sync_fifo_ctl: DEPTH must be >= 2");
  end
  if (AFULL_LEVEL > DEPTH) begin : g_bad_afull
    $fatal(1, "sync_fifo_ctl: AFULL_LEVEL must be <= DEPTH");
  end
  if (AEMPTY_LEVEL >= DEPTH) begin : g_bad_aempty
    $fatal(1, "sync_fifo_ctl: AEMPTY_LEVEL must be < DEPTH");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_inc, rd_ptr_inc;
  logic             wr_ok, rd_ok, ov_set, un_set;
  logic [CW-1:0]    cnt_nxt;

  // Flush masks both requests, so they neither move state nor raise errors.
  assign rd_ok  = rd & ~empty & ~flush;
  assign wr_ok  = wr & (~full | rd_ok) & ~flush;
  assign ov_set = wr & ~wr_ok & ~flush;
  assign un_set = rd & ~rd_ok & ~flush;

  // Explicit wrap keeps pointers correct for non-power-of-two depths.
  assign wr_ptr_inc = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
  assign rd_ptr_inc = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);

  always_comb begin
    cnt_nxt = count;
    if (flush)               cnt_nxt = '0;
    else if (wr_ok && !rd_ok) cnt_nxt = count + CNT_ONE;
    else if (rd_ok && !wr_ok) cnt_nxt = count - CNT_ONE;
  end

  always_ff @(posedge clock) begin
    if (wr_ok && !reset) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      dout         <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= (AFULL_LEVEL == 0);
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_ok) wr_ptr <= wr_ptr_inc;
        if (rd_ok) rd_ptr <= rd_ptr_inc;
      end
      count        <= cnt_nxt;
      full         <= (cnt_nxt == CNT_MAX);
      empty        <= (cnt_nxt == '0);
      almost_full  <= (cnt_nxt >= AF_LVL);
      almost_empty <= (cnt_nxt <= AE_LVL);
      overflow     <= (overflow & ~clear_errors) | ov_set;
      underflow    <= (underflow & ~clear_errors) | un_set;
      if (FWFT == 0) begin
        if (rd_ok) dout <= mem[rd_ptr];
      end else begin
        // dout mirrors mem[rd_ptr]; a word written this edge is bypassed when it becomes head.
        if (rd_ok && count > CNT_ONE)
          dout <= mem[rd_ptr_inc];
        else if (wr_ok && (empty || (rd_ok && count == CNT_ONE)))
          dout <= din;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Bench for sync_fifo_ctl: three configurations share one stimulus stream and are
// compared every cycle against a queue-based model, plus directed checks.
module tb_sync_fifo_ctl;

  localparam int N = 3;
  localparam int DEP [N] = '{5, 4, 6};
  localparam int FW  [N] = '{0, 1, 0};
  localparam int AFL [N] = '{4, 3, 4};
  localparam int AEL [N] = '{1, 1, 2};

  logic       clock = 1'b0;
  logic       reset, wr, rd, flush, clear_errors;
  logic [7:0] din;

  logic [7:0] dout_o  [N];
  logic [2:0] count_o [N];
  logic       full_o [N], empty_o [N], af_o [N], ae_o [N], ov_o [N], un_o [N];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] mq [N][$];
  logic [7:0] md [N];
  bit         mov [N], mun [N];

  always #5 clock = ~clock;

  for (genvar g = 0; g < N; g++) begin : g_dut
    sync_fifo_ctl #(
      .WIDTH(8), .DEPTH(DEP[g]), .FWFT(FW[g]),
      .AFULL_LEVEL(AFL[g]), .AEMPTY_LEVEL(AEL[g])
    ) u_dut (
      .clock(clock), .reset(reset), .din(din), .wr(wr), .rd(rd),
      .flush(flush), .clear_errors(clear_errors),
      .dout(dout_o[g]), .full(full_o[g]), .empty(empty_o[g]),
      .almost_full(af_o[g]), .almost_empty(ae_o[g]), .count(count_o[g]),
      .overflow(ov_o[g]), .underflow(un_o[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit w, input bit r, input bit fl, input bit c,
                            input bit rs, input logic [7:0] d);
    for (int k = 0; k < N; k++) begin
      if (rs) begin
        mq[k].delete(); md[k] = 8'h00; mov[k] = 0; mun[k] = 0;
      end else if (fl) begin
        mq[k].delete();
        mov[k] = mov[k] && !c;
        mun[k] = mun[k] && !c;
      end else begin
        bit rok, wok;
        logic [7:0] v;
        rok = r && (mq[k].size() > 0);
        wok = w && ((mq[k].size() < DEP[k]) || rok);
        mov[k] = (mov[k] && !c) || (w && !wok);
        mun[k] = (mun[k] && !c) || (r && !rok);
        if (rok) begin
          v = mq[k].pop_front();
          if (FW[k] == 0) md[k] = v;
        end
        if (wok) mq[k].push_back(d);
        if (FW[k] != 0 && mq[k].size() > 0) md[k] = mq[k][0];
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < N; k++) begin
      int s;
      s = mq[k].size();
      chk($sformatf("u%0d.dout", k),         32'(dout_o[k]),  32'(md[k]));
      chk($sformatf("u%0d.count", k),        32'(count_o[k]), 32'(s));
      chk($sformatf("u%0d.full", k),         32'(full_o[k]),  32'(s == DEP[k]));
      chk($sformatf("u%0d.empty", k),        32'(empty_o[k]), 32'(s == 0));
      chk($sformatf("u%0d.almost_full", k),  32'(af_o[k]),    32'(s >= AFL[k]));
      chk($sformatf("u%0d.almost_empty", k), 32'(ae_o[k]),    32'(s <= AEL[k]));
      chk($sformatf("u%0d.overflow", k),     32'(ov_o[k]),    32'(mov[k]));
      chk($sformatf("u%0d.underflow", k),    32'(un_o[k]),    32'(mun[k]));
    end
  endtask

  task automatic step(input bit w, input bit r, input bit fl, input bit c,
                      input bit rs, input logic [7:0] d);
    wr = w; rd = r; flush = fl; clear_errors = c; reset = rs; din = d;
    @(posedge clock);
    model_edge(w, r, fl, c, rs, d);
    #1;
    compare_all();
  endtask

  task automatic do_reset();  step(0, 0, 0, 0, 1, 8'h00); endtask
  task automatic push(input logic [7:0] d); step(1, 0, 0, 0, 0, d); endtask
  task automatic pop();       step(0, 1, 0, 0, 0, 8'h00); endtask

  initial begin
    reset = 1'b1; wr = 0; rd = 0; flush = 0; clear_errors = 0; din = '0;
    @(negedge clock);

    // Reset state
    do_reset();
    chk("rst.count", 32'(count_o[0]), 0);
    chk("rst.empty", 32'(empty_o[0]), 1);
    chk("rst.dout",  32'(dout_o[1]),  0);

    // Fill and drain on the DEPTH=5 standard-mode instance
    for (int i = 1; i <= 5; i++) push(8'(i));
    chk("fill.full",  32'(full_o[0]),  1);
    chk("fill.count", 32'(count_o[0]), 5);
    push(8'hAA);
    chk("fill.overflow", 32'(ov_o[0]),    1);
    chk("fill.count6",   32'(count_o[0]), 5);
    for (int i = 1; i <= 5; i++) begin
      pop();
      chk($sformatf("drain.dout%0d", i), 32'(dout_o[0]), 32'(i));
    end
    chk("drain.empty", 32'(empty_o[0]), 1);
    pop();
    chk("drain.underflow", 32'(un_o[0]),   1);
    chk("drain.dout_hold", 32'(dout_o[0]), 32'h05);

    // FWFT on the DEPTH=4 instance
    do_reset();
    push(8'h3C);
    chk("fwft.empty", 32'(empty_o[1]), 0);
    chk("fwft.dout",  32'(dout_o[1]),  32'h3C);
    chk("fwft.count", 32'(count_o[1]), 1);
    step(1, 1, 0, 0, 0, 8'h5A);
    chk("fwft.rw_dout",  32'(dout_o[1]),  32'h5A);
    chk("fwft.rw_count", 32'(count_o[1]), 1);

    // Simultaneous rd/wr when full and when empty
    do_reset();
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
    step(1, 1, 0, 0, 0, 8'h14);
    chk("rw_full.count", 32'(count_o[1]), 4);
    chk("rw_full.ov",    32'(ov_o[1]),    0);
    do_reset();
    step(1, 1, 0, 0, 0, 8'h77);
    chk("rw_empty.count", 32'(count_o[1]), 1);
    chk("rw_empty.un",    32'(un_o[1]),    1);

    // Wrap with 3 words in flight and thresholds on the DEPTH=6 instance
    do_reset();
    for (int i = 0; i < 3; i++) push(8'h40 + 8'(i));
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, 0, 0, 8'h43 + 8'(i));
      chk($sformatf("wrap.dout%0d", i), 32'(dout_o[2]), 32'h40 + 32'(i));
    end
    push(8'hEE);
    chk("thr.af_at4", 32'(af_o[2]), 1);
    chk("thr.ae_at4", 32'(ae_o[2]), 0);
    pop();
    chk("thr.af_at3", 32'(af_o[2]), 0);
    chk("thr.ae_at3", 32'(ae_o[2]), 0);
    pop();
    chk("thr.ae_at2", 32'(ae_o[2]), 1);
    pop();
    chk("thr.ae_at1", 32'(ae_o[2]), 1);

    // Flush with pending rd and wr
    do_reset();
    for (int i = 0; i < 3; i++) push(8'h60 + 8'(i));
    step(1, 1, 1, 0, 0, 8'h99);
    chk("flush.count", 32'(count_o[2]), 0);
    chk("flush.empty", 32'(empty_o[2]), 1);
    chk("flush.ov",    32'(ov_o[2]),    0);
    chk("flush.un",    32'(un_o[2]),    0);

    // clear_errors racing a new overflow, then alone
    do_reset();
    for (int i = 0; i < 6; i++) push(8'h80 + 8'(i));
    step(1, 0, 0, 1, 0, 8'hF0);
    chk("clr.ov_kept", 32'(ov_o[2]), 1);
    step(0, 0, 0, 1, 0, 8'h00);
    chk("clr.ov_clear", 32'(ov_o[2]), 0);

    // Reset mid-operation, concurrent with a write
    do_reset();
    for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
    pop();
    chk("rstmid.pre_count", 32'(count_o[1]), 3);
    chk("rstmid.pre_ov",    32'(ov_o[1]),    1);
    step(1, 0, 0, 0, 1, 8'hDD);
    chk("rstmid.count", 32'(count_o[1]), 0);
    chk("rstmid.dout",  32'(dout_o[1]),  0);
    chk("rstmid.empty", 32'(empty_o[1]), 1);
    chk("rstmid.ov",    32'(ov_o[1]),    0);
    step(0, 0, 0, 0, 0, 8'h00);
    chk("rstmid.discard", 32'(count_o[1]), 0);

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(bit'($urandom_range(0, 99) < 55), bit'($urandom_range(0, 99) < 50),
           bit'($urandom_range(0, 39) == 0), bit'($urandom_range(0, 15) == 0),
           bit'($urandom_range(0, 79) == 0), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctl.md
Name: sync_fifo_ctl

Overview:
Single-clock, parametrised FIFO built on inferred RAM. It is the next generation of the dual-clock primitive-based FIFO wrapper, and is used inside one clock domain: command queues and the motor-step buffers in the driver board. Compared with the primitive wrapper it adds:
- arbitrary width and depth
- a first-word-fall-through (FWFT) mode
- programmable almost-full and almost-empty levels
- a fill count
- a synchronous flush
- sticky overflow and underflow error flags

Parameters:
- WIDTH, 8: data width in bits, 1..256.
- DEPTH, 8: storage depth in words, 2..4096. Need not be a power of two.
- FWFT, 0: read mode. 0 = standard (registered read); 1 = first-word-fall-through.
- AFULL_LEVEL, DEPTH-1: almost_full asserts when count >= AFULL_LEVEL.
- AEMPTY_LEVEL, 1: almost_empty asserts when count <= AEMPTY_LEVEL.
- CW, $clog2(DEPTH+1): width of count. Derived; not overridden.

Ports:
- clock  in  1  Sole clock; all logic on the rising edge.
- reset  in  1  Synchronous, active-high reset.
- din  in  WIDTH  Write data.
- wr  in  1  Write request.
- rd  in  1  Read request.
- flush  in  1  Synchronous empty-out without reset.
- clear_errors  in  1  Clears overflow and underflow.
- dout  out  WIDTH  Read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_LEVEL.
- almost_empty  out  1  count <= AEMPTY_LEVEL.
- count  out  CW  Words held. In FWFT mode this includes the word presented on dout.
- overflow  out  1  Sticky: a write was rejected.
- underflow  out  1  Sticky: a read was rejected.

Behaviour:
- Reset (synchronous, active-high; wins over all other inputs):
  - count=0, pointers=0, dout=0.
  - empty=1, full=0, almost_empty=1, almost_full=(AFULL_LEVEL==0).
  - overflow=0, underflow=0.
  - RAM contents are not cleared.
- Acceptance:
  - wr_ok = wr & (~full | rd_ok).
  - rd_ok = rd & ~empty.
  - Both are evaluated on the current (pre-edge) flags.
- Simultaneous rd and wr:
  - When full: both are accepted; count is unchanged.
  - When empty: the write is accepted; the read is rejected and sets underflow.
- Rejections:
  - A rejected write does not modify RAM or pointers and sets overflow.
  - A rejected read sets underflow.
- Pointers: wrap from DEPTH-1 to 0. Pointer arithmetic must be correct for non-power-of-two DEPTH.
- Flags and count:
  - count += wr_ok - rd_ok each edge.
  - All flags are registered and derived from the next-state count, so they are valid in the cycle after the causing edge.
- Standard mode (FWFT=0):
  - An accepted read at edge N loads the head word into dout; dout is valid after edge N.
  - dout holds its value until the next accepted read.
  - Read latency is 1 cycle.
- FWFT mode (FWFT=1):
  - Whenever empty=0, dout shows the head word.
  - rd_ok pops the head; the next word appears on dout after that same edge.
  - A write into an empty FIFO at edge N gives empty=0 and dout=that word after edge N (bypass/output register).
  - When empty, dout holds its last value.
- flush:
  - At the edge, count=0, pointers realign, empty=1, and the flags update.
  - wr and rd in the same cycle as flush are ignored and do not set the error flags.
  - dout holds its value.
  - Reset has priority over flush.
- Error flags:
  - overflow and underflow stay set until clear_errors or reset.
  - If clear_errors and a new error occur in the same cycle, the flag remains set.
- Elaboration checks: elaboration fails via an assertion if DEPTH<2, AFULL_LEVEL>DEPTH or AEMPTY_LEVEL>=DEPTH.

Test Plan:
- Fill and drain, WIDTH=8, DEPTH=5, FWFT=0:
  - Write 0x01..0x05 -> full=1, count=5.
  - A 6th write of 0xAA -> overflow=1, count stays 5.
  - Read 5 times -> dout sequence 0x01..0x05, each valid 1 cycle after its rd; then empty=1.
  - A 6th read -> underflow=1, dout stays 0x05.
- FWFT, DEPTH=4:
  - Write 0x3C into empty at edge N -> after N, empty=0, dout=0x3C, count=1.
  - rd with a write of 0x5A in the same cycle -> dout=0x5A, count=1.
- Simultaneous rd/wr, DEPTH=4:
  - Full -> both accepted, count=4, no overflow.
  - Empty -> count=1, underflow=1.
- Wrap and thresholds, DEPTH=6, AFULL_LEVEL=4, AEMPTY_LEVEL=2:
  - 20 interleaved write/read cycles keeping 3 words in flight -> data order preserved across pointer wrap.
  - almost_full=1 at count 4; almost_empty=1 at counts 2 and below.
- Flush and clear_errors:
  - With count=3 plus a pending rd and wr, pulse flush -> count=0, empty=1, no error flags set.
  - Pulse clear_errors alongside a fresh overflow -> overflow stays 1; a following clear_errors alone -> overflow=0.
- Reset mid-operation:
  - With count=3 and overflow=1, assert reset for 1 cycle concurrently with wr -> count=0, dout=0, empty=1, overflow=0.
  - The write is discarded.
